// File: rtl/sbox_walk_multi.sv
// Table-free AES S-box / inverse S-box over LANES bytes: walks p = 3^k with q = p^-1
// and lets each lane capture its result when its byte lines up with the walk.
module sbox_walk_multi #(
  parameter int LANES = 20
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               inv_i,
  input  logic [8*LANES-1:0] idx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [8*LANES-1:0] dout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'd254;

  state_t             state_q;
  logic [7:0]         p_q;
  logic [7:0]         q_q;
  logic [7:0]         step_q;
  logic [LANES-1:0]   res_q;
  logic [8*LANES-1:0] idx_q;
  logic [8*LANES-1:0] dout_q;
  logic               inv_q;
  logic               busy_q;
  logic               done_q;

  logic [7:0]         aff_d;
  logic [7:0]         p_d;
  logic [7:0]         q_d;
  logic [LANES-1:0]   hit_d;
  logic [LANES-1:0]   cap_d;
  logic [8*LANES-1:0] cap_val_d;
  logic               all_res_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // 0xF6 is the inverse of 0x03, so q tracks p^-1 and aff(q) is S(p).
  always_comb begin
    p_d   = xtime(p_q) ^ p_q;
    q_d   = gmul(q_q, 8'hF6);
    aff_d = q_q ^ {q_q[6:0], q_q[7]} ^ {q_q[5:0], q_q[7:6]}
          ^ {q_q[4:0], q_q[7:5]} ^ {q_q[3:0], q_q[7:4]} ^ 8'h63;
  end

  always_comb begin
    hit_d     = '0;
    cap_val_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!inv_q) begin
        if (idx_q[8*i +: 8] == 8'h00) begin
          hit_d[i]            = 1'b1;
          cap_val_d[8*i +: 8] = 8'h63;
        end else if (idx_q[8*i +: 8] == p_q) begin
          hit_d[i]            = 1'b1;
          cap_val_d[8*i +: 8] = aff_d;
        end
      end else begin
        if (idx_q[8*i +: 8] == 8'h63) begin
          hit_d[i]            = 1'b1;
          cap_val_d[8*i +: 8] = 8'h00;
        end else if (idx_q[8*i +: 8] == aff_d) begin
          hit_d[i]            = 1'b1;
          cap_val_d[8*i +: 8] = p_q;
        end
      end
    end
    cap_d     = hit_d & ~res_q;
    all_res_d = &(res_q | hit_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      p_q     <= 8'h01;
      q_q     <= 8'h01;
      step_q  <= 8'd0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= WALK;
            busy_q  <= 1'b1;
            idx_q   <= idx_i;
            inv_q   <= inv_i;
            dout_q  <= '0;
            res_q   <= '0;
            p_q     <= 8'h01;
            q_q     <= 8'h01;
            step_q  <= 8'd0;
          end
        end
        WALK: begin
          for (int i = 0; i < LANES; i++) begin
            if (cap_d[i]) dout_q[8*i +: 8] <= cap_val_d[8*i +: 8];
          end
          res_q  <= res_q | hit_d;
          step_q <= step_q + 8'd1;
          p_q    <= p_d;
          q_q    <= q_d;
          // Every byte is reached by step 254, so that step always ends the walk.
          if (all_res_d || (step_q == LAST_STEP)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dout_o = dout_q;

endmodule

// File: tb/tb_sbox_walk_multi.sv
// Self-checking bench for sbox_walk_multi: directed table, handshake sequences,
// exhaustive sweep and random operations against an arithmetic S-box model.
module tb_sbox_walk_multi;
  localparam int LANES = 20;
  localparam int W     = 8 * LANES;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         inv = 1'b0;
  logic [W-1:0] idx = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb [256];
  logic [7:0] isb[256];
  int         lg [256];

  typedef struct {
    string        tag;
    logic         m;
    logic [W-1:0] v;
    logic [W-1:0] e;
    int           cyc;
  } vec_t;

  vec_t tbl[$];

  sbox_walk_multi #(.LANES(LANES)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .start_i(start),
    .inv_i  (inv),
    .idx_i  (idx),
    .busy_o (busy),
    .done_o (done),
    .dout_o (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Polynomial product then reduction by 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int r;
    int ai;
    r  = 0;
    ai = a;
    for (int i = 0; i < 8; i++) if (b[i]) r = r ^ (ai << i);
    for (int i = 14; i >= 8; i--) if (r[i]) r = r ^ (32'h11B << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] q);
    int x;
    int s;
    x = q;
    s = x ^ 8'h63;
    for (int n = 1; n <= 4; n++) s = s ^ (((x << n) | (x >> (8 - n))) & 255);
    return s[7:0];
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic model(input logic m, input logic [W-1:0] v, output logic [W-1:0] e, output int cyc);
    int mx;
    int s;
    logic [7:0] b;
    mx = 0;
    e  = '0;
    for (int i = 0; i < LANES; i++) begin
      b = v[8*i +: 8];
      if (!m) begin
        e[8*i +: 8] = sb[b];
        s = (b == 8'h00) ? 0 : lg[b];
      end else begin
        e[8*i +: 8] = isb[b];
        s = (b == 8'h63) ? 0 : lg[isb[b]];
      end
      if (s > mx) mx = s;
    end
    cyc = mx + 2;
  endtask

  // Starts in an IDLE cycle; scribbles inputs and pulses start while busy.
  task automatic run_op(input string tag, input logic m, input logic [W-1:0] v,
                        input logic [W-1:0] e, input int ecyc);
    int cyc;
    logic [W-1:0] got;
    start = 1'b1;
    inv   = m;
    idx   = v;
    @(posedge clk); #1;
    cyc = 1;
    chk({tag, " busy_rise"}, W'(busy), W'(1));
    while (!done && cyc < 300) begin
      start = ($urandom_range(0, 3) == 0);
      inv   = 1'($urandom_range(0, 1));
      idx   = rand_vec();
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    got = dout;
    chk({tag, " done_cycle"}, W'(cyc), W'(ecyc));
    chk({tag, " dout"}, got, e);
    chk({tag, " busy_at_done"}, W'(busy), W'(1));
    @(posedge clk); #1;
    chk({tag, " idle_busy_done"}, W'({busy, done}), W'(0));
    chk({tag, " dout_held"}, dout, e);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] v;
    int           ecyc;
    int           pw;
    int           cyc;
    vec_t         t;

    // Reference tables straight from the field arithmetic.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] q;
      q = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) q = 8'(y);
      sb[x] = affine(q);
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    lg[0] = 0;
    pw = 1;
    for (int k = 0; k < 255; k++) begin
      lg[pw] = k;
      pw = gm(8'(pw), 8'h03);
    end

    t.tag = "fwd_mixed"; t.m = 1'b0; t.cyc = 0;
    t.v = {LANES{8'h01}}; t.e = {LANES{8'h7C}};
    t.v[7:0] = 8'h00;   t.e[7:0] = 8'h63;
    t.v[23:16] = 8'h53; t.e[23:16] = 8'hED;
    t.v[31:24] = 8'h02; t.e[31:24] = 8'h77;
    tbl.push_back(t);
    t.tag = "early_01_00"; t.m = 1'b0; t.cyc = 2;
    t.v = {LANES{8'h01}}; t.e = {LANES{8'h7C}};
    t.v[39:32] = 8'h00; t.e[39:32] = 8'h63;
    tbl.push_back(t);
    t.tag = "step1_03"; t.m = 1'b0; t.cyc = 3;
    t.v = {LANES{8'h03}}; t.e = {LANES{8'h7B}};
    tbl.push_back(t);
    t.tag = "worst_F6"; t.m = 1'b0; t.cyc = 256;
    t.v = {LANES{8'h01}}; t.e = {LANES{8'h7C}};
    t.v[55:48] = 8'hF6; t.e[55:48] = 8'h42;
    tbl.push_back(t);
    t.tag = "inverse"; t.m = 1'b1; t.cyc = 256;
    t.v = {LANES{8'h7C}}; t.e = {LANES{8'h01}};
    t.v[15:8] = 8'h63;  t.e[15:8] = 8'h00;
    t.v[23:16] = 8'hED; t.e[23:16] = 8'h53;
    t.v[31:24] = 8'h42; t.e[31:24] = 8'hF6;
    tbl.push_back(t);
    t.tag = "dup_53"; t.m = 1'b0; t.cyc = 0;
    t.v = {LANES{8'h53}}; t.e = {LANES{8'hED}};
    tbl.push_back(t);

    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_busy_done", W'({busy, done}), W'(0));
    chk("reset_dout", dout, '0);

    foreach (tbl[n]) begin
      model(tbl[n].m, tbl[n].v, e, ecyc);
      run_op(tbl[n].tag, tbl[n].m, tbl[n].v, tbl[n].e, (tbl[n].cyc > 0) ? tbl[n].cyc : ecyc);
    end

    // Reset in cycle 10 of a long operation, then a fresh operation.
    v = {LANES{8'h01}};
    v[7:0] = 8'hF6;
    start = 1'b1; inv = 1'b0; idx = v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midwalk_reset_busy_done", W'({busy, done}), W'(0));
    chk("midwalk_reset_dout", dout, '0);
    @(posedge clk); #1;
    chk("post_reset_stays_idle", W'(busy), W'(0));
    v = rand_vec();
    model(1'b0, v, e, ecyc);
    run_op("after_reset", 1'b0, v, e, ecyc);

    // Back-to-back: second start held high through WALK and DONE.
    start = 1'b1; inv = 1'b0; idx = {LANES{8'h01}};
    @(posedge clk); #1;
    idx = {LANES{8'h03}};
    chk("b2b_c1_busy", W'(busy), W'(1));
    @(posedge clk); #1;
    chk("b2b_c2_done", W'({busy, done}), W'(3));
    chk("b2b_c2_dout", dout, {LANES{8'h7C}});
    @(posedge clk); #1;
    chk("b2b_c3_idle", W'({busy, done}), W'(0));
    chk("b2b_c3_dout_held", dout, {LANES{8'h7C}});
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_c4_busy", W'(busy), W'(1));
    chk("b2b_c4_dout_cleared", dout, '0);
    cyc = 4;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("b2b_second_done_cycle", W'(cyc), W'(6));
    chk("b2b_second_dout", dout, {LANES{8'h7B}});
    @(posedge clk); #1;

    for (int m = 0; m < 2; m++) begin
      for (int base = 0; base < 256; base += LANES) begin
        for (int i = 0; i < LANES; i++) v[8*i +: 8] = 8'((base + i) & 255);
        model(1'(m), v, e, ecyc);
        run_op(m ? "exh_inv" : "exh_fwd", 1'(m), v, e, ecyc);
      end
    end

    for (int r = 0; r < 20; r++) begin
      logic rm;
      rm = 1'($urandom_range(0, 1));
      v = rand_vec();
      if (r % 4 == 0) for (int i = 1; i < LANES; i += 2) v[8*i +: 8] = v[7:0];
      model(rm, v, e, ecyc);
      run_op("random", rm, v, e, ecyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
